// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display blocks.
// Provides the scan state encoding, the active-low segment codes (gfedcba)
// and the helper that sizes the digit index register.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Width of the digit index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: purely combinational hex digit to active-low 7-segment decoder.
// Output bit 0 is segment a, bit 6 is segment g.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Look up the segment pattern for the incoming nibble.
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed driver for a common-anode 7-segment display.
// The divider's slow_clk is edge-detected in the clk domain and used as a
// scan tick; each tick moves to the next digit, blanks all anodes for
// BLANK_CYCLES clocks to avoid ghosting, then drives the decoded digit.
// The whole value/dp word is sampled once per frame so a frame is coherent.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    slow_clk,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int                IDX_W    = idx_width(N_DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]        CNT_LAST = 8'(BLANK_CYCLES - 1);

  logic                   slow_q;
  logic                   tick;
  scan_state_t            state;
  scan_state_t            state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic [7:0]             cnt;
  logic [7:0]             cnt_nxt;
  logic                   frame_latch;
  logic [4*N_DIGITS-1:0]  shadow;
  logic [N_DIGITS-1:0]    dp_shadow;
  logic [3:0]             nibble;
  logic [6:0]             seg_dec;
  logic                   lz_blank;
  logic [N_DIGITS-1:0]    an_nxt;
  logic [6:0]             seg_nxt;
  logic                   dp_nxt;

  assign tick = slow_clk & ~slow_q;

  // Delay slow_clk by one clk so its rising edge becomes a single-cycle tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slow_q <= 1'b0;
    end else begin
      slow_q <= slow_clk;
    end
  end

  // Next-state logic: a tick always restarts the gap on the next digit;
  // otherwise BLANK counts out the gap and DRIVE simply holds.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    frame_latch = 1'b0;
    if (tick) begin
      idx_nxt     = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      cnt_nxt     = '0;
      state_nxt   = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
      frame_latch = (idx == IDX_LAST);
    end else begin
      case (state)
        ST_BLANK: begin
          cnt_nxt = cnt + 8'd1;
          if ((BLANK_CYCLES == 0) || (cnt == CNT_LAST)) begin
            state_nxt = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          state_nxt = ST_DRIVE;
        end
        default: begin
          state_nxt = ST_BLANK;
        end
      endcase
    end
  end

  // Scan state, digit index, gap counter and the per-frame value snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_BLANK;
      idx       <= '0;
      cnt       <= '0;
      shadow    <= '0;
      dp_shadow <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (frame_latch) begin
        shadow    <= value;
        dp_shadow <= dp_in;
      end
    end
  end

  assign nibble = shadow[4*idx +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (nibble),
    .seg (seg_dec)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign lz_blank = (idx != '0) && ((shadow >> (4*idx)) == '0);
`else
  assign lz_blank = 1'b0;
`endif

  // Select what the display should show for the current state and digit.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (state == ST_DRIVE) begin
      an_nxt  = ~(N_DIGITS'(1) << idx);
      seg_nxt = lz_blank ? SEG_OFF : seg_dec;
      dp_nxt  = ~dp_shadow[idx];
    end
  end

  // Register the pad outputs so the display pins are glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule
